control_fsm: RTL and testbench
==============================

# control_fsm

Multi-cycle RV32I control unit sitting directly upstream of `data_path`. It watches the latched `instruction` word and sequences FETCH → DECODE → EXECUTE → (MEMORY/BRANCH) → WRITEBACK. In each state it drives every datapath control input and the memory write strobe. `data_path` and `control_fsm` together form the complete core.

## Interface
- No parameters.
- `clk` in 1: single core clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; state → FETCH immediately.
- `instruction` in 32: latched instruction from `data_path`.
- `execute_result_write_enable`, `load_memory_data_write_enable`, `pc_write_enable`, `instruction_write_enable`, `register_file_write_enable`, `source_write_enable` out 1 each: datapath register strobes.
- `write_immediate_to_register_file`, `write_load_memory_to_register_file`, `write_pc_inc_to_register_file` out 1 each: register-file write-data select.
- `write_execute_result_to_pc`, `write_execute_result_to_pc_if_compare_met` out 1 each: PC source select.
- `use_execute_result_for_read_memory`, `use_immediate`, `use_pc_for_alu` out 1 each: operand and address muxes.
- `execute_alu`, `execute_compare`, `execute_shift` out 1 each: execute-result source (one-hot or all 0).
- `immediate_type` out 3: 0=I, 1=S, 2=B, 3=U, 4=J.
- `alu_type` out 3: 0=add, 1=sub, 2=and, 3=or, 4=xor.
- `compare_type` out 3: branch funct3 encoding (0 eq, 1 ne, 4 lt, 5 ge, 6 ltu, 7 geu).
- `shift_type` out 2: 0=sll, 1=srl, 2=sra.
- `load_memory_decoder_type` out 3: load funct3.
- `store_memory_encoder_type` out 2: store funct3[1:0].
- `write_memory_enable` out 1: memory write strobe.
- `halted` out 1: core stopped.
- `debug_state` out 3: current state encoding.

## Operation
- State encodings: FETCH=0, DECODE=1, EXECUTE=2, MEMORY_READ=3, MEMORY_WRITE=4, BRANCH=5, WRITEBACK=6, HALT=7.
- All outputs are combinational from state and `instruction`. Any signal not listed for a state is 0.
- **FETCH**: `instruction_write_enable`=1 (PC-addressed memory read). → DECODE.
- **DECODE**: `source_write_enable`=1. Next state by opcode:
  - LUI, FENCE → WRITEBACK.
  - SYSTEM or unknown opcode → HALT.
  - All others → EXECUTE.
- **EXECUTE**: `execute_result_write_enable`=1.
  - OP-IMM/OP, funct3 0/4/6/7: `execute_alu`; `alu_type` add/xor/or/and. OP funct3 0 with funct7[5]=1 selects sub.
  - funct3 2/3: `execute_compare`; `compare_type` 4 or 6.
  - funct3 1/5: `execute_shift`; `shift_type` sll, or srl/sra per funct7[5].
  - OP-IMM also sets `use_immediate`=1, `immediate_type`=I.
  - AUIPC, JAL: `execute_alu` add, `use_pc_for_alu`, `use_immediate`, type U/J.
  - JALR, LOAD: source1+imm(I).
  - STORE: source1+imm(S).
  - BRANCH: pc+imm(B).
  - Next state: LOAD → MEMORY_READ, STORE → MEMORY_WRITE, BRANCH → BRANCH, else → WRITEBACK.
- **MEMORY_READ**: `use_execute_result_for_read_memory`, `load_memory_data_write_enable`, `load_memory_decoder_type`=funct3. → WRITEBACK.
- **MEMORY_WRITE**: `write_memory_enable`, `store_memory_encoder_type`=funct3[1:0], `pc_write_enable`. → FETCH.
- **BRANCH**: `use_immediate`=0, `compare_type`=funct3, `write_execute_result_to_pc_if_compare_met`, `pc_write_enable`. → FETCH.
- **WRITEBACK**: `pc_write_enable`=1 and `register_file_write_enable`=(rd≠0), except FENCE (never writes).
  - LUI: `immediate_type`=U, `write_immediate_to_register_file`.
  - LOAD: `write_load_memory_to_register_file`.
  - JAL/JALR: `write_pc_inc_to_register_file`, `write_execute_result_to_pc`.
  - → FETCH.
- **HALT**: `halted`=1; all strobes 0; remains until reset.
- JALR target bit 0 is not cleared. Misaligned accesses are not trapped.

## Timing
- Reset: state=FETCH. While `reset`=1 all enables/strobes are forced to 0, `halted`=0, `debug_state`=0.
- Latency in cycles: LUI/FENCE 3; OP/OP-IMM/AUIPC/JAL/JALR/STORE/BRANCH 4; LOAD 5.
- Reset mid-instruction: abandons the instruction with no further register, PC or memory write. Fetch resumes from the reset PC on the first cycle after deassertion.
- Exactly one `pc_write_enable` pulse per retired instruction; none in HALT.
- `register_file_write_enable` only in WRITEBACK; `write_memory_enable` only in MEMORY_WRITE.

## Test plan
- **ADDI**: `addi x1,x0,5` (0x00500093).
  - `debug_state` sequence 0,1,2,6,0.
  - EXECUTE: `execute_alu`=1, `alu_type`=0, `use_immediate`=1, `immediate_type`=0.
  - WRITEBACK: `register_file_write_enable`=1, `pc_write_enable`=1.
- **BEQ**: `beq x0,x0,+8` (0x00000463).
  - EXECUTE: `use_pc_for_alu`=1, `immediate_type`=2.
  - BRANCH (state 5): `compare_type`=0, `use_immediate`=0, `write_execute_result_to_pc_if_compare_met`=1, `pc_write_enable`=1.
  - Total 4 cycles.
- **LW**: `lw x2,4(x1)` (0x0040A103).
  - States 0,1,2,3,6.
  - MEMORY_READ: `use_execute_result_for_read_memory`=1, `load_memory_decoder_type`=2.
  - WRITEBACK: `write_load_memory_to_register_file`=1.
- **SW**: `sw x2,4(x1)` (0x0020A223).
  - States 0,1,2,4.
  - MEMORY_WRITE: `write_memory_enable`=1, `store_memory_encoder_type`=2, `pc_write_enable`=1.
  - `register_file_write_enable` never 1.
- **JAL with rd=0**: `jal x0,+16` (0x0100006F).
  - WRITEBACK: `write_execute_result_to_pc`=1, `register_file_write_enable`=0.
- **ECALL and reset**: `ecall` (0x00000073) → `debug_state`=7, `halted`=1, no strobes for 20 cycles. Then assert `reset` mid-LW in MEMORY_READ → immediate FETCH, no WRITEBACK strobe.

Source files
------------

// File: rtl/control_fsm.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXECUTE/MEMORY/BRANCH/WRITEBACK
// and drives every data_path control input from the current state and latched instruction.
module control_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    output logic        execute_result_write_enable,
    output logic        load_memory_data_write_enable,
    output logic        pc_write_enable,
    output logic        instruction_write_enable,
    output logic        register_file_write_enable,
    output logic        source_write_enable,
    output logic        write_immediate_to_register_file,
    output logic        write_load_memory_to_register_file,
    output logic        write_pc_inc_to_register_file,
    output logic        write_execute_result_to_pc,
    output logic        write_execute_result_to_pc_if_compare_met,
    output logic        use_execute_result_for_read_memory,
    output logic        use_immediate,
    output logic        use_pc_for_alu,
    output logic        execute_alu,
    output logic        execute_compare,
    output logic        execute_shift,
    output logic [2:0]  immediate_type,
    output logic [2:0]  alu_type,
    output logic [2:0]  compare_type,
    output logic [1:0]  shift_type,
    output logic [2:0]  load_memory_decoder_type,
    output logic [1:0]  store_memory_encoder_type,
    output logic        write_memory_enable,
    output logic        halted,
    output logic [2:0]  debug_state
);

    typedef enum logic [2:0] {
        FETCH        = 3'd0,
        DECODE       = 3'd1,
        EXECUTE      = 3'd2,
        MEMORY_READ  = 3'd3,
        MEMORY_WRITE = 3'd4,
        BRANCH       = 3'd5,
        WRITEBACK    = 3'd6,
        HALT         = 3'd7
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;

    localparam logic [2:0] CMP_LT  = 3'd4;
    localparam logic [2:0] CMP_LTU = 3'd6;

    localparam logic [1:0] SH_SLL = 2'd0;
    localparam logic [1:0] SH_SRL = 2'd1;
    localparam logic [1:0] SH_SRA = 2'd2;

    state_t state;
    state_t next_state;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       rd_nonzero;
    logic       unused_instruction_bits;

    assign opcode     = instruction[6:0];
    assign funct3     = instruction[14:12];
    assign funct7_b5  = instruction[30];
    assign rd_nonzero = (instruction[11:7] != 5'd0);
    assign unused_instruction_bits = ^{instruction[31], instruction[29:15]};

    always_comb begin
        next_state = state;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (opcode)
                    OPC_LUI, OPC_FENCE:                        next_state = WRITEBACK;
                    OPC_OP_IMM, OPC_OP, OPC_AUIPC, OPC_JAL,
                    OPC_JALR, OPC_LOAD, OPC_STORE, OPC_BRANCH: next_state = EXECUTE;
                    default:                                   next_state = HALT;
                endcase
            end
            EXECUTE: begin
                case (opcode)
                    OPC_LOAD:   next_state = MEMORY_READ;
                    OPC_STORE:  next_state = MEMORY_WRITE;
                    OPC_BRANCH: next_state = BRANCH;
                    default:    next_state = WRITEBACK;
                endcase
            end
            MEMORY_READ:  next_state = WRITEBACK;
            MEMORY_WRITE: next_state = FETCH;
            BRANCH:       next_state = FETCH;
            WRITEBACK:    next_state = FETCH;
            HALT:         next_state = HALT;
            default:      next_state = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= FETCH;
        else
            state <= next_state;
    end

    // Outputs are purely combinational; reset masks everything so an abandoned
    // instruction cannot leak a register, PC or memory write.
    always_comb begin
        execute_result_write_enable               = 1'b0;
        load_memory_data_write_enable             = 1'b0;
        pc_write_enable                           = 1'b0;
        instruction_write_enable                  = 1'b0;
        register_file_write_enable                = 1'b0;
        source_write_enable                       = 1'b0;
        write_immediate_to_register_file          = 1'b0;
        write_load_memory_to_register_file        = 1'b0;
        write_pc_inc_to_register_file             = 1'b0;
        write_execute_result_to_pc                = 1'b0;
        write_execute_result_to_pc_if_compare_met = 1'b0;
        use_execute_result_for_read_memory        = 1'b0;
        use_immediate                             = 1'b0;
        use_pc_for_alu                            = 1'b0;
        execute_alu                               = 1'b0;
        execute_compare                           = 1'b0;
        execute_shift                             = 1'b0;
        immediate_type                            = IMM_I;
        alu_type                                  = ALU_ADD;
        compare_type                              = 3'd0;
        shift_type                                = SH_SLL;
        load_memory_decoder_type                  = 3'd0;
        store_memory_encoder_type                 = 2'd0;
        write_memory_enable                       = 1'b0;
        halted                                    = 1'b0;
        debug_state                               = state;

        if (!reset) begin
            case (state)
                FETCH:  instruction_write_enable = 1'b1;
                DECODE: source_write_enable = 1'b1;
                EXECUTE: begin
                    execute_result_write_enable = 1'b1;
                    case (opcode)
                        OPC_OP_IMM, OPC_OP: begin
                            use_immediate = (opcode == OPC_OP_IMM);
                            case (funct3)
                                3'd0: begin
                                    execute_alu = 1'b1;
                                    alu_type = (opcode == OPC_OP && funct7_b5) ? ALU_SUB : ALU_ADD;
                                end
                                3'd4: begin execute_alu = 1'b1; alu_type = ALU_XOR; end
                                3'd6: begin execute_alu = 1'b1; alu_type = ALU_OR;  end
                                3'd7: begin execute_alu = 1'b1; alu_type = ALU_AND; end
                                3'd2: begin execute_compare = 1'b1; compare_type = CMP_LT;  end
                                3'd3: begin execute_compare = 1'b1; compare_type = CMP_LTU; end
                                3'd1: begin execute_shift = 1'b1; shift_type = SH_SLL; end
                                default: begin
                                    execute_shift = 1'b1;
                                    shift_type = funct7_b5 ? SH_SRA : SH_SRL;
                                end
                            endcase
                        end
                        OPC_AUIPC, OPC_JAL, OPC_BRANCH: begin
                            execute_alu    = 1'b1;
                            use_pc_for_alu = 1'b1;
                            use_immediate  = 1'b1;
                            immediate_type = (opcode == OPC_AUIPC) ? IMM_U :
                                             (opcode == OPC_JAL)   ? IMM_J : IMM_B;
                        end
                        OPC_JALR, OPC_LOAD, OPC_STORE: begin
                            execute_alu    = 1'b1;
                            use_immediate  = 1'b1;
                            immediate_type = (opcode == OPC_STORE) ? IMM_S : IMM_I;
                        end
                        default: ;
                    endcase
                end
                MEMORY_READ: begin
                    use_execute_result_for_read_memory = 1'b1;
                    load_memory_data_write_enable      = 1'b1;
                    load_memory_decoder_type           = funct3;
                end
                MEMORY_WRITE: begin
                    write_memory_enable       = 1'b1;
                    store_memory_encoder_type = funct3[1:0];
                    pc_write_enable           = 1'b1;
                end
                BRANCH: begin
                    compare_type                              = funct3;
                    write_execute_result_to_pc_if_compare_met = 1'b1;
                    pc_write_enable                           = 1'b1;
                end
                WRITEBACK: begin
                    pc_write_enable            = 1'b1;
                    register_file_write_enable = rd_nonzero && (opcode != OPC_FENCE);
                    case (opcode)
                        OPC_LUI: begin
                            immediate_type                   = IMM_U;
                            write_immediate_to_register_file = 1'b1;
                        end
                        OPC_LOAD: write_load_memory_to_register_file = 1'b1;
                        OPC_JAL, OPC_JALR: begin
                            write_pc_inc_to_register_file = 1'b1;
                            write_execute_result_to_pc    = 1'b1;
                        end
                        default: ;
                    endcase
                end
                HALT:    halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: per-cycle vector table over several instruction
// classes, then hand-written halt-persistence and reset-mid-instruction sequences.
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        execute_result_write_enable, load_memory_data_write_enable, pc_write_enable;
    logic        instruction_write_enable, register_file_write_enable, source_write_enable;
    logic        write_immediate_to_register_file, write_load_memory_to_register_file;
    logic        write_pc_inc_to_register_file, write_execute_result_to_pc;
    logic        write_execute_result_to_pc_if_compare_met, use_execute_result_for_read_memory;
    logic        use_immediate, use_pc_for_alu, execute_alu, execute_compare, execute_shift;
    logic [2:0]  immediate_type, alu_type, compare_type, load_memory_decoder_type, debug_state;
    logic [1:0]  shift_type, store_memory_encoder_type;
    logic        write_memory_enable, halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_fsm dut (
        .clk(clk),
        .reset(reset),
        .instruction(instruction),
        .execute_result_write_enable(execute_result_write_enable),
        .load_memory_data_write_enable(load_memory_data_write_enable),
        .pc_write_enable(pc_write_enable),
        .instruction_write_enable(instruction_write_enable),
        .register_file_write_enable(register_file_write_enable),
        .source_write_enable(source_write_enable),
        .write_immediate_to_register_file(write_immediate_to_register_file),
        .write_load_memory_to_register_file(write_load_memory_to_register_file),
        .write_pc_inc_to_register_file(write_pc_inc_to_register_file),
        .write_execute_result_to_pc(write_execute_result_to_pc),
        .write_execute_result_to_pc_if_compare_met(write_execute_result_to_pc_if_compare_met),
        .use_execute_result_for_read_memory(use_execute_result_for_read_memory),
        .use_immediate(use_immediate),
        .use_pc_for_alu(use_pc_for_alu),
        .execute_alu(execute_alu),
        .execute_compare(execute_compare),
        .execute_shift(execute_shift),
        .immediate_type(immediate_type),
        .alu_type(alu_type),
        .compare_type(compare_type),
        .shift_type(shift_type),
        .load_memory_decoder_type(load_memory_decoder_type),
        .store_memory_encoder_type(store_memory_encoder_type),
        .write_memory_enable(write_memory_enable),
        .halted(halted),
        .debug_state(debug_state)
    );

    // One-bit output flags, packed in the order used by observed().
    localparam logic [18:0] ERW   = 19'h00001;
    localparam logic [18:0] LMW   = 19'h00002;
    localparam logic [18:0] PCW   = 19'h00004;
    localparam logic [18:0] IRW   = 19'h00008;
    localparam logic [18:0] RFW   = 19'h00010;
    localparam logic [18:0] SRW   = 19'h00020;
    localparam logic [18:0] WIMM  = 19'h00040;
    localparam logic [18:0] WLD   = 19'h00080;
    localparam logic [18:0] WPCI  = 19'h00100;
    localparam logic [18:0] WEPC  = 19'h00200;
    localparam logic [18:0] WEPCC = 19'h00400;
    localparam logic [18:0] UERM  = 19'h00800;
    localparam logic [18:0] UIMM  = 19'h01000;
    localparam logic [18:0] UPC   = 19'h02000;
    localparam logic [18:0] EALU  = 19'h04000;
    localparam logic [18:0] ECMP  = 19'h08000;
    localparam logic [18:0] ESH   = 19'h10000;
    localparam logic [18:0] WME   = 19'h20000;
    localparam logic [18:0] HLT   = 19'h40000;

    localparam logic [31:0] I_ADDI  = 32'h00500093;
    localparam logic [31:0] I_SUB   = 32'h402081B3;
    localparam logic [31:0] I_SRAI  = 32'h4030D293;
    localparam logic [31:0] I_SLTU  = 32'h0020B333;
    localparam logic [31:0] I_BEQ   = 32'h00000463;
    localparam logic [31:0] I_BNE   = 32'h00209463;
    localparam logic [31:0] I_LW    = 32'h0040A103;
    localparam logic [31:0] I_SW    = 32'h0020A223;
    localparam logic [31:0] I_JAL0  = 32'h0100006F;
    localparam logic [31:0] I_JALR  = 32'h000100E7;
    localparam logic [31:0] I_LUI   = 32'h123453B7;
    localparam logic [31:0] I_FENCE = 32'h0FF0008F;
    localparam logic [31:0] I_ECALL = 32'h00000073;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        rst;
        logic [37:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [37:0] pack(input logic [2:0] st, input logic [18:0] fl,
                                         input logic [2:0] imm = 3'd0, input logic [2:0] alu = 3'd0,
                                         input logic [2:0] cmp = 3'd0, input logic [1:0] sh = 2'd0,
                                         input logic [2:0] ld = 3'd0, input logic [1:0] sto = 2'd0);
        return {st, fl, imm, alu, cmp, sh, ld, sto};
    endfunction

    function automatic logic [37:0] observed();
        return {debug_state,
                halted, write_memory_enable, execute_shift, execute_compare, execute_alu,
                use_pc_for_alu, use_immediate, use_execute_result_for_read_memory,
                write_execute_result_to_pc_if_compare_met, write_execute_result_to_pc,
                write_pc_inc_to_register_file, write_load_memory_to_register_file,
                write_immediate_to_register_file, source_write_enable,
                register_file_write_enable, instruction_write_enable, pc_write_enable,
                load_memory_data_write_enable, execute_result_write_enable,
                immediate_type, alu_type, compare_type, shift_type,
                load_memory_decoder_type, store_memory_encoder_type};
    endfunction

    task automatic add(input string name, input logic [31:0] instr, input logic rst,
                       input logic [37:0] exp);
        vec_t v;
        v.name = name;
        v.instr = instr;
        v.rst = rst;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic addFetchDecode(input string name, input logic [31:0] instr);
        add({name, "_fetch"}, instr, 1'b0, pack(3'd0, IRW));
        add({name, "_decode"}, instr, 1'b0, pack(3'd1, SRW));
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic rst);
        instruction = instr;
        reset = rst;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [37:0] exp);
        logic [37:0] got;
        got = observed();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got state=%0d flags=%05h fields=%04h, expected state=%0d flags=%05h fields=%04h",
                     name, got[37:35], got[34:16], got[15:0], exp[37:35], exp[34:16], exp[15:0]);
        end
    endtask

    initial begin
        add("reset", I_LW, 1'b1, pack(3'd0, 19'd0));

        addFetchDecode("addi", I_ADDI);
        add("addi_exec", I_ADDI, 1'b0, pack(3'd2, ERW | EALU | UIMM));
        add("addi_wb",   I_ADDI, 1'b0, pack(3'd6, PCW | RFW));

        addFetchDecode("sub", I_SUB);
        add("sub_exec", I_SUB, 1'b0, pack(3'd2, ERW | EALU, 3'd0, 3'd1));
        add("sub_wb",   I_SUB, 1'b0, pack(3'd6, PCW | RFW));

        addFetchDecode("srai", I_SRAI);
        add("srai_exec", I_SRAI, 1'b0, pack(3'd2, ERW | ESH | UIMM, 3'd0, 3'd0, 3'd0, 2'd2));
        add("srai_wb",   I_SRAI, 1'b0, pack(3'd6, PCW | RFW));

        addFetchDecode("sltu", I_SLTU);
        add("sltu_exec", I_SLTU, 1'b0, pack(3'd2, ERW | ECMP, 3'd0, 3'd0, 3'd6));
        add("sltu_wb",   I_SLTU, 1'b0, pack(3'd6, PCW | RFW));

        addFetchDecode("beq", I_BEQ);
        add("beq_exec",   I_BEQ, 1'b0, pack(3'd2, ERW | EALU | UIMM | UPC, 3'd2));
        add("beq_branch", I_BEQ, 1'b0, pack(3'd5, WEPCC | PCW, 3'd0, 3'd0, 3'd0));

        addFetchDecode("bne", I_BNE);
        add("bne_exec",   I_BNE, 1'b0, pack(3'd2, ERW | EALU | UIMM | UPC, 3'd2));
        add("bne_branch", I_BNE, 1'b0, pack(3'd5, WEPCC | PCW, 3'd0, 3'd0, 3'd1));

        addFetchDecode("lw", I_LW);
        add("lw_exec", I_LW, 1'b0, pack(3'd2, ERW | EALU | UIMM));
        add("lw_mem",  I_LW, 1'b0, pack(3'd3, UERM | LMW, 3'd0, 3'd0, 3'd0, 2'd0, 3'd2));
        add("lw_wb",   I_LW, 1'b0, pack(3'd6, PCW | RFW | WLD));

        addFetchDecode("sw", I_SW);
        add("sw_exec", I_SW, 1'b0, pack(3'd2, ERW | EALU | UIMM, 3'd1));
        add("sw_mem",  I_SW, 1'b0, pack(3'd4, WME | PCW, 3'd0, 3'd0, 3'd0, 2'd0, 3'd0, 2'd2));

        addFetchDecode("jal0", I_JAL0);
        add("jal0_exec", I_JAL0, 1'b0, pack(3'd2, ERW | EALU | UIMM | UPC, 3'd4));
        add("jal0_wb",   I_JAL0, 1'b0, pack(3'd6, PCW | WPCI | WEPC));

        addFetchDecode("jalr", I_JALR);
        add("jalr_exec", I_JALR, 1'b0, pack(3'd2, ERW | EALU | UIMM));
        add("jalr_wb",   I_JALR, 1'b0, pack(3'd6, PCW | RFW | WPCI | WEPC));

        addFetchDecode("lui", I_LUI);
        add("lui_wb", I_LUI, 1'b0, pack(3'd6, PCW | RFW | WIMM, 3'd3));

        addFetchDecode("fence", I_FENCE);
        add("fence_wb", I_FENCE, 1'b0, pack(3'd6, PCW));

        addFetchDecode("ecall", I_ECALL);
        add("ecall_halt", I_ECALL, 1'b0, pack(3'd7, HLT));

        reset = 1'b1;
        instruction = 32'd0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].instr, vecs[i].rst);
            checkOutput(vecs[i].name, vecs[i].exp);
            @(posedge clk);
            #1;
        end

        // HALT must hold with no strobes until reset.
        for (int c = 0; c < 20; c++) begin
            applyStimulus(I_ECALL, 1'b0);
            checkOutput($sformatf("halt_hold%0d", c), pack(3'd7, HLT));
            @(posedge clk);
            #1;
        end

        // Reset asserted mid-cycle while a load is in MEMORY_READ.
        applyStimulus(I_LW, 1'b1);
        checkOutput("halt_reset", pack(3'd0, 19'd0));
        @(posedge clk);
        #1;
        applyStimulus(I_LW, 1'b0);
        checkOutput("lw2_fetch", pack(3'd0, IRW));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("lw2_mem", pack(3'd3, UERM | LMW, 3'd0, 3'd0, 3'd0, 2'd0, 3'd2));
        #3;
        reset = 1'b1;
        #1;
        checkOutput("lw2_async_reset", pack(3'd0, 19'd0));
        @(posedge clk);
        #1;
        checkOutput("lw2_reset_held", pack(3'd0, 19'd0));
        applyStimulus(I_LW, 1'b0);
        checkOutput("after_reset_fetch", pack(3'd0, IRW));
        @(posedge clk);
        #1;
        checkOutput("after_reset_decode", pack(3'd1, SRW));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
